// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI4 responder backed by a DEPTH x 64-bit internal memory. Read and write
// channels run independent state machines and may be busy at the same time.
// FIXED and INCR bursts of 1..256 beats and sizes up to 8 bytes are served.
// Byte lanes are written according to wstrb only. Illegal commands and beats
// outside the memory window complete normally on the bus but answer SLVERR.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_aw*                    write address channel (valid/ready/addr/id/len/size/burst)
//   s_w*                     write data channel (valid/ready/data/strb/last)
//   s_b*                     write response channel (valid/ready/resp/id)
//   s_ar*                    read address channel (valid/ready/addr/id/len/size/burst)
//   s_r*                     read data channel (valid/ready/data/resp/last/id)
module axi_sram_slave #(
  parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          IDW       = 4
) (
  input  logic           clk,
  input  logic           rst,
  // write address
  input  logic           s_awvalid,
  output logic           s_awready,
  input  logic [63:0]    s_awaddr,
  input  logic [IDW-1:0] s_awid,
  input  logic [7:0]     s_awlen,
  input  logic [2:0]     s_awsize,
  input  logic [1:0]     s_awburst,
  // write data
  input  logic           s_wvalid,
  output logic           s_wready,
  input  logic [63:0]    s_wdata,
  input  logic [7:0]     s_wstrb,
  input  logic           s_wlast,
  // write response
  output logic           s_bvalid,
  input  logic           s_bready,
  output logic [1:0]     s_bresp,
  output logic [IDW-1:0] s_bid,
  // read address
  input  logic           s_arvalid,
  output logic           s_arready,
  input  logic [63:0]    s_araddr,
  input  logic [IDW-1:0] s_arid,
  input  logic [7:0]     s_arlen,
  input  logic [2:0]     s_arsize,
  input  logic [1:0]     s_arburst,
  // read data
  output logic           s_rvalid,
  input  logic           s_rready,
  output logic [63:0]    s_rdata,
  output logic [1:0]     s_rresp,
  output logic           s_rlast,
  output logic [IDW-1:0] s_rid
);

  localparam int         IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

  logic [63:0] mem [DEPTH];

  // A beat touches memory only if it lies inside the window.
  function automatic logic in_range(input logic [63:0] a);
    return (a >= ADDR_BASE) && (((a - ADDR_BASE) >> 3) < 64'(DEPTH));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [63:0] a);
    return IW'((a - ADDR_BASE) >> 3);
  endfunction

  function automatic logic cmd_legal(input logic [2:0] size, input logic [1:0] burst);
    return (size <= 3'd3) && ((burst == BURST_FIXED) || (burst == BURST_INCR));
  endfunction

  // INCR realigns to the transfer size before stepping, so an unaligned
  // first beat lands on an aligned second beat.
  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [63:0] step;
    step = 64'd1 << size;
    if (burst == BURST_FIXED) return a;
    return (a & ~(step - 64'd1)) + step;
  endfunction

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wstate_e        wstate_q, wstate_d;
  logic [63:0]    waddr_q, waddr_d;
  logic [IDW-1:0] wid_q, wid_d;
  logic [7:0]     wlen_q, wlen_d;
  logic [2:0]     wsize_q, wsize_d;
  logic [1:0]     wburst_q, wburst_d;
  logic [7:0]     wcnt_q, wcnt_d;
  logic           werr_q, werr_d;
  logic           aw_hs, w_hs, b_hs;
  logic           w_last_beat, w_commit;
  logic [IW-1:0]  w_idx;

  assign aw_hs       = s_awvalid && s_awready;
  assign w_hs        = s_wvalid && s_wready;
  assign b_hs        = s_bvalid && s_bready;
  assign w_last_beat = (wcnt_q == wlen_q);
  assign w_idx       = word_idx(waddr_q);

  always_ff @(posedge clk) begin
    if (rst) wstate_q <= W_IDLE;
    else     wstate_q <= wstate_d;
  end

  // Burst end is decided by the local beat counter; wlast is only checked.
  always_comb begin
    wstate_d = wstate_q;
    unique case (wstate_q)
      W_IDLE:  if (aw_hs) wstate_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) wstate_d = W_RESP;
      W_RESP:  if (b_hs) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RESP_OKAY;
    s_bid     = '0;
    if (!rst) begin
      unique case (wstate_q)
        W_IDLE: s_awready = 1'b1;
        W_DATA: s_wready  = 1'b1;
        W_RESP: begin
          s_bvalid = 1'b1;
          s_bresp  = werr_q ? RESP_SLVERR : RESP_OKAY;
          s_bid    = wid_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    waddr_d  = waddr_q;
    wid_d    = wid_q;
    wlen_d   = wlen_q;
    wsize_d  = wsize_q;
    wburst_d = wburst_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    w_commit = 1'b0;
    if (aw_hs) begin
      waddr_d  = s_awaddr;
      wid_d    = s_awid;
      wlen_d   = s_awlen;
      wsize_d  = s_awsize;
      wburst_d = s_awburst;
      wcnt_d   = '0;
      werr_d   = 1'b0;
    end else if (w_hs) begin
      w_commit = in_range(waddr_q) && cmd_legal(wsize_q, wburst_q);
      if (!w_commit) werr_d = 1'b1;
      if (s_wlast != w_last_beat) werr_d = 1'b1;
      waddr_d = next_addr(waddr_q, wsize_q, wburst_q);
      wcnt_d  = wcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      werr_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      werr_q <= werr_d;
    end
  end

  always_ff @(posedge clk) begin
    waddr_q  <= waddr_d;
    wid_q    <= wid_d;
    wlen_q   <= wlen_d;
    wsize_q  <= wsize_d;
    wburst_q <= wburst_d;
  end

  // Narrow writes rely on wstrb alone; size and low address bits do not mask lanes.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 8; b++) begin
        if (s_wstrb[b]) mem[w_idx][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rstate_e        rstate_q, rstate_d;
  logic [63:0]    raddr_q, raddr_d;
  logic [IDW-1:0] rid_q, rid_d;
  logic [7:0]     rlen_q, rlen_d;
  logic [2:0]     rsize_q, rsize_d;
  logic [1:0]     rburst_q, rburst_d;
  logic [7:0]     rcnt_q, rcnt_d;
  logic [63:0]    rdata_q;
  logic           rerr_q;
  logic           ar_hs, r_hs, r_last;
  logic           r_load, r_load_ok;
  logic [63:0]    r_load_addr;

  assign ar_hs  = s_arvalid && s_arready;
  assign r_hs   = s_rvalid && s_rready;
  assign r_last = (rcnt_q == rlen_q);

  always_ff @(posedge clk) begin
    if (rst) rstate_q <= R_IDLE;
    else     rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    unique case (rstate_q)
      R_IDLE:  if (ar_hs) rstate_d = R_DATA;
      R_DATA:  if (r_hs && r_last) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = RESP_OKAY;
    s_rlast   = 1'b0;
    s_rid     = '0;
    if (!rst) begin
      unique case (rstate_q)
        R_IDLE: s_arready = 1'b1;
        R_DATA: begin
          s_rvalid = 1'b1;
          s_rdata  = rdata_q;
          s_rresp  = rerr_q ? RESP_SLVERR : RESP_OKAY;
          s_rlast  = r_last;
          s_rid    = rid_q;
        end
        default: ;
      endcase
    end
  end

  // The next beat is fetched on the same edge that retires the current one,
  // giving one beat per cycle; the output register holds during a stall.
  always_comb begin
    raddr_d     = raddr_q;
    rid_d       = rid_q;
    rlen_d      = rlen_q;
    rsize_d     = rsize_q;
    rburst_d    = rburst_q;
    rcnt_d      = rcnt_q;
    r_load      = 1'b0;
    r_load_addr = raddr_q;
    r_load_ok   = 1'b0;
    if (ar_hs) begin
      raddr_d     = s_araddr;
      rid_d       = s_arid;
      rlen_d      = s_arlen;
      rsize_d     = s_arsize;
      rburst_d    = s_arburst;
      rcnt_d      = '0;
      r_load      = 1'b1;
      r_load_addr = s_araddr;
      r_load_ok   = in_range(s_araddr) && cmd_legal(s_arsize, s_arburst);
    end else if (r_hs && !r_last) begin
      raddr_d     = next_addr(raddr_q, rsize_q, rburst_q);
      rcnt_d      = rcnt_q + 8'd1;
      r_load      = 1'b1;
      r_load_addr = raddr_d;
      r_load_ok   = in_range(raddr_d) && cmd_legal(rsize_q, rburst_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '0;
    else     rcnt_q <= rcnt_d;
  end

  always_ff @(posedge clk) begin
    raddr_q  <= raddr_d;
    rid_q    <= rid_d;
    rlen_q   <= rlen_d;
    rsize_q  <= rsize_d;
    rburst_q <= rburst_d;
  end

  // Memory is sampled before any same-edge write lands, so a colliding read
  // returns the previous contents.
  always_ff @(posedge clk) begin
    if (r_load) begin
      rdata_q <= r_load_ok ? mem[word_idx(r_load_addr)] : 64'd0;
      rerr_q  <= !r_load_ok;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          IDW   = 4;

  logic clk, rst;
  logic s_awvalid, s_awready; logic [63:0] s_awaddr; logic [IDW-1:0] s_awid;
  logic [7:0] s_awlen; logic [2:0] s_awsize; logic [1:0] s_awburst;
  logic s_wvalid, s_wready; logic [63:0] s_wdata; logic [7:0] s_wstrb; logic s_wlast;
  logic s_bvalid, s_bready; logic [1:0] s_bresp; logic [IDW-1:0] s_bid;
  logic s_arvalid, s_arready; logic [63:0] s_araddr; logic [IDW-1:0] s_arid;
  logic [7:0] s_arlen; logic [2:0] s_arsize; logic [1:0] s_arburst;
  logic s_rvalid, s_rready; logic [63:0] s_rdata; logic [1:0] s_rresp; logic s_rlast;
  logic [IDW-1:0] s_rid;

  axi_sram_slave #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [63:0] mm [DEPTH];
  logic [7:0]  km [DEPTH];          // which bytes of each word are known
  int          wph, rph;            // write: 0 addr,1 data,2 resp ; read: 0 addr,1 data
  logic [63:0] m_waddr, m_raddr;
  logic [7:0]  m_wlen, m_rlen;
  int          m_wcnt, m_rcnt, m_idx;
  logic [2:0]  m_wsize, m_rsize;
  logic [1:0]  m_wburst, m_rburst;
  logic [IDW-1:0] m_wid, m_rid;
  bit          m_werr;
  logic [63:0] e_rdata;
  logic [7:0]  e_rknown;
  logic [1:0]  e_rresp;

  function automatic bit f_in_range(input logic [63:0] a);
    return (a >= BASE) && ((a - BASE) / 8 < 64'(DEPTH));
  endfunction
  function automatic int f_idx(input logic [63:0] a);
    return int'((a - BASE) / 8);
  endfunction
  function automatic bit f_legal(input logic [2:0] size, input logic [1:0] burst);
    return (size < 3'd4) && (burst == 2'b00 || burst == 2'b01);
  endfunction
  function automatic logic [63:0] f_step(input logic [63:0] a, input logic [2:0] size,
                                         input logic [1:0] burst);
    logic [63:0] n;
    n = 64'd1 << size;
    if (burst == 2'b00) return a;
    return a - (a % n) + n;
  endfunction
  function automatic logic [63:0] bytemask(input logic [7:0] k);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction
  function automatic void m_load(input logic [63:0] a);
    if (f_legal(m_rsize, m_rburst) && f_in_range(a)) begin
      e_rresp = 2'b00; e_rdata = mm[f_idx(a)]; e_rknown = km[f_idx(a)];
    end else begin
      e_rresp = 2'b10; e_rdata = 64'd0; e_rknown = 8'hFF;
    end
  endfunction

  // Compare, then advance the model by the handshakes of the coming edge.
  // Inputs only change just after posedge, so negedge values are what the DUT samples.
  initial begin
    wph = 0; rph = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ctrl", {s_awready, s_wready, s_bvalid, s_bresp, s_bid, s_arready, s_rvalid,
                         s_rresp, s_rlast, s_rid}, 64'd0);
        chk("rst_rdata", s_rdata, 64'd0);
        wph = 0; rph = 0;
      end else begin
        chk("awready", s_awready, 64'(wph == 0));
        chk("wready", s_wready, 64'(wph == 1));
        chk("bvalid", s_bvalid, 64'(wph == 2));
        if (wph == 2) begin
          chk("bresp", s_bresp, m_werr ? 64'd2 : 64'd0);
          chk("bid", s_bid, m_wid);
        end
        chk("arready", s_arready, 64'(rph == 0));
        chk("rvalid", s_rvalid, 64'(rph == 1));
        if (rph == 1) begin
          chk("rid", s_rid, m_rid);
          chk("rresp", s_rresp, e_rresp);
          chk("rlast", s_rlast, 64'(m_rcnt == int'(m_rlen)));
          chk("rdata", s_rdata & bytemask(e_rknown), e_rdata & bytemask(e_rknown));
        end
        // read side first: a load sees memory before any same-edge write
        if (rph == 0) begin
          if (s_arvalid) begin
            m_raddr = s_araddr; m_rid = s_arid; m_rlen = s_arlen;
            m_rsize = s_arsize; m_rburst = s_arburst; m_rcnt = 0;
            m_load(m_raddr); rph = 1;
          end
        end else if (s_rready) begin
          if (m_rcnt == int'(m_rlen)) rph = 0;
          else begin
            m_rcnt++; m_raddr = f_step(m_raddr, m_rsize, m_rburst); m_load(m_raddr);
          end
        end
        if (wph == 0) begin
          if (s_awvalid) begin
            m_waddr = s_awaddr; m_wid = s_awid; m_wlen = s_awlen;
            m_wsize = s_awsize; m_wburst = s_awburst; m_wcnt = 0; m_werr = 0; wph = 1;
          end
        end else if (wph == 1) begin
          if (s_wvalid) begin
            if (f_legal(m_wsize, m_wburst) && f_in_range(m_waddr)) begin
              m_idx = f_idx(m_waddr);
              for (int b = 0; b < 8; b++)
                if (s_wstrb[b]) begin
                  mm[m_idx][8*b +: 8] = s_wdata[8*b +: 8]; km[m_idx][b] = 1'b1;
                end
            end else m_werr = 1;
            if (s_wlast != (m_wcnt == int'(m_wlen))) m_werr = 1;
            if (m_wcnt == int'(m_wlen)) wph = 2;
            else begin m_wcnt++; m_waddr = f_step(m_waddr, m_wsize, m_wburst); end
          end
        end else if (s_bready) wph = 0;
      end
    end
  end

  // ---------------- drivers ----------------
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic [1:0]  last_bresp;
  logic [63:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic        rq_last[$];
  int          rtog;

  function automatic bit hs(input int ch);
    case (ch)
      0: return s_awvalid && s_awready;
      1: return s_wvalid && s_wready;
      2: return s_bvalid && s_bready;
      3: return s_arvalid && s_arready;
      4: return s_rvalid && s_rready;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rb(input int i);
    return (i < rq_data.size()) ? rq_data[i] : 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction
  function automatic logic [1:0] rr(input int i);
    return (i < rq_resp.size()) ? rq_resp[i] : 2'b11;
  endfunction

  // Called just after a posedge; returns just after the posedge of the handshake.
  task automatic wait_hs(input int ch, input int mode);
    int n;
    bit ok;
    n = 0; ok = 0;
    while (!ok && n < 200) begin
      if (ch == 2) s_bready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (ch == 4) begin
        if (mode == 0)      s_rready = 1'b1;
        else if (mode == 1) s_rready = 1'($urandom_range(0, 1));
        else begin s_rready = (rtog % 2 == 0); rtog++; end
      end
      @(negedge clk);
      if (hs(ch)) begin
        ok = 1;
        if (ch == 2) last_bresp = s_bresp;
        if (ch == 4) begin
          rq_data.push_back(s_rdata); rq_resp.push_back(s_rresp); rq_last.push_back(s_rlast);
        end
      end
      n++;
      @(posedge clk); #1;
    end
    chk($sformatf("handshake_ch%0d", ch), 64'(ok), 64'd1);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [IDW-1:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit badlast,
                          input int mode);
    s_awaddr = addr; s_awid = id; s_awlen = len; s_awsize = size; s_awburst = burst;
    s_awvalid = 1'b1;
    wait_hs(0, 0);
    s_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (mode != 0) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      s_wdata = wd[b]; s_wstrb = ws[b];
      s_wlast = (b == int'(len)) || (badlast && b == 0);
      s_wvalid = 1'b1;
      wait_hs(1, 0);
      s_wvalid = 1'b0; s_wlast = 1'b0;
    end
    wait_hs(2, mode);
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [IDW-1:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode);
    rq_data.delete(); rq_resp.delete(); rq_last.delete();
    s_araddr = addr; s_arid = id; s_arlen = len; s_arsize = size; s_arburst = burst;
    s_arvalid = 1'b1;
    wait_hs(3, 0);
    s_arvalid = 1'b0;
    rtog = 0;
    for (int b = 0; b <= int'(len); b++) wait_hs(4, mode);
    s_rready = 1'b0;
  endtask

  task automatic rand_cmd(output logic [63:0] a, output logic [7:0] len,
                          output logic [2:0] size, output logic [1:0] burst);
    int r;
    r = $urandom_range(0, 99);
    if (r < 6)      a = BASE + 64'((DEPTH - 2) * 8);
    else if (r < 9) a = BASE - 64'd8;
    else            a = BASE + 64'(8 * $urandom_range(0, 31) + $urandom_range(0, 7));
    r = $urandom_range(0, 99);
    size  = (r < 8) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    r = $urandom_range(0, 99);
    burst = (r < 8) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
    len = 8'($urandom_range(0, 7));
  endtask

  localparam logic [63:0] VA  = 64'hAAAA_0000_1111_0001;
  localparam logic [63:0] VB  = 64'hBBBB_0000_2222_0002;
  localparam logic [63:0] OLD = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] NEW = 64'hFEDC_BA98_7654_3210;

  initial begin
    for (int i = 0; i < DEPTH; i++) km[i] = 8'h00;
    rst = 1'b1;
    s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_rready = 0; rtog = 0;
    @(negedge clk);
    chk("reset_awready", s_awready, 64'd0);
    chk("reset_arready", s_arready, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_awready", s_awready, 64'd1);
    chk("idle_arready", s_arready, 64'd1);
    @(posedge clk); #1;

    // single write then read
    wd[0] = 64'h1122_3344_5566_7788; ws[0] = 8'hFF;
    do_write(BASE + 64'h8, 4'h3, 8'd0, 3'd3, 2'b01, 0, 0);
    chk("t1_bresp", last_bresp, 64'd0);
    do_read(BASE + 64'h8, 4'h5, 8'd0, 3'd3, 2'b01, 0);
    chk("t1_rdata", rb(0), 64'h1122_3344_5566_7788);
    chk("t1_rresp", rr(0), 64'd0);

    // INCR burst with read backpressure
    wd[0] = VA; wd[1] = VB; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_write(BASE, 4'h1, 8'd1, 3'd3, 2'b01, 0, 0);
    do_read(BASE, 4'h2, 8'd1, 3'd3, 2'b01, 2);
    chk("t2_beatA", rb(0), VA);
    chk("t2_beatB", rb(1), VB);
    chk("t2_lasts", {rq_last.size() > 1 ? rq_last[1] : 1'b0, rq_last.size() > 0 ? rq_last[0] : 1'b1}, 64'b10);

    // strobes
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
    do_write(BASE + 64'h10, 4'h0, 8'd0, 3'd3, 2'b01, 0, 0);
    wd[0] = 64'd0; ws[0] = 8'h0F;
    do_write(BASE + 64'h10, 4'h0, 8'd0, 3'd3, 2'b01, 0, 0);
    do_read(BASE + 64'h10, 4'h0, 8'd0, 3'd3, 2'b01, 0);
    chk("t3_strb", rb(0), 64'hFFFF_FFFF_0000_0000);

    // errors
    do_read(BASE + 64'(DEPTH * 8), 4'h7, 8'd0, 3'd3, 2'b01, 0);
    chk("t4_oor_resp", rr(0), 64'd2);
    chk("t4_oor_data", rb(0), 64'd0);
    wd[0] = 64'h1; wd[1] = 64'h2;
    do_write(BASE, 4'h9, 8'd1, 3'd3, 2'b10, 0, 0);
    chk("t5_wrap_bresp", last_bresp, 64'd2);
    do_read(BASE, 4'h2, 8'd1, 3'd3, 2'b01, 0);
    chk("t5_keepA", rb(0), VA);
    chk("t5_keepB", rb(1), VB);
    wd[0] = 64'h3; wd[1] = 64'h4;
    do_write(BASE + 64'h20, 4'hA, 8'd1, 3'd3, 2'b01, 1, 0);
    chk("t6_wlast_bresp", last_bresp, 64'd2);

    // concurrency
    for (int k = 0; k < 4; k++) begin wd[k] = 64'hC0C0_0000_0000_0000 + 64'(k); ws[k] = 8'hFF; end
    do_write(BASE + 64'h200, 4'h1, 8'd3, 3'd3, 2'b01, 0, 0);
    for (int k = 0; k < 4; k++) wd[k] = 64'h5757_0000_0000_0000 + 64'(k);
    fork
      do_write(BASE + 64'h100, 4'h4, 8'd3, 3'd3, 2'b01, 0, 1);
      do_read(BASE + 64'h200, 4'h6, 8'd3, 3'd3, 2'b01, 1);
    join
    for (int k = 0; k < 4; k++) chk("t7_read", rb(k), 64'hC0C0_0000_0000_0000 + 64'(k));
    do_read(BASE + 64'h100, 4'h6, 8'd3, 3'd3, 2'b01, 0);
    for (int k = 0; k < 4; k++) chk("t7_wrote", rb(k), 64'h5757_0000_0000_0000 + 64'(k));

    // same-word collision: read load on the edge of the write commit
    wd[0] = OLD; ws[0] = 8'hFF;
    do_write(BASE + 64'h300, 4'h0, 8'd0, 3'd3, 2'b01, 0, 0);
    s_awaddr = BASE + 64'h300; s_awlen = 0; s_awsize = 3; s_awburst = 2'b01; s_awvalid = 1'b1;
    wait_hs(0, 0);
    s_awvalid = 1'b0;
    s_wdata = NEW; s_wstrb = 8'hFF; s_wlast = 1'b1; s_wvalid = 1'b1;
    s_araddr = BASE + 64'h300; s_arlen = 0; s_arsize = 3; s_arburst = 2'b01; s_arvalid = 1'b1;
    @(negedge clk);
    chk("t8_same_edge", {hs(1), hs(3)}, 64'b11);
    @(posedge clk); #1;
    s_wvalid = 1'b0; s_wlast = 1'b0; s_arvalid = 1'b0;
    rq_data.delete(); rq_resp.delete(); rq_last.delete();
    wait_hs(4, 0);
    s_rready = 1'b0;
    chk("t8_old", rb(0), OLD);
    wait_hs(2, 0);
    s_bready = 1'b0;
    do_read(BASE + 64'h300, 4'h0, 8'd0, 3'd3, 2'b01, 0);
    chk("t8_new", rb(0), NEW);

    // reset in the middle of a read burst
    s_araddr = BASE + 64'h200; s_arlen = 3; s_arsize = 3; s_arburst = 2'b01; s_arvalid = 1'b1;
    wait_hs(3, 0);
    s_arvalid = 1'b0;
    wait_hs(4, 0);
    s_rready = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t9_rvalid_in_rst", s_rvalid, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t9_rvalid_after", s_rvalid, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t9_arready", s_arready, 64'd1);
    chk("t9_rvalid_idle", s_rvalid, 64'd0);
    @(posedge clk); #1;
    do_read(BASE + 64'h200, 4'h2, 8'd3, 3'd3, 2'b01, 0);
    for (int k = 0; k < 4; k++) chk("t9_reread", rb(k), 64'hC0C0_0000_0000_0000 + 64'(k));

    // randomized concurrent traffic, checked cycle by cycle by the model
    fork
      begin
        logic [63:0] a; logic [7:0] l; logic [2:0] sz; logic [1:0] bu;
        for (int i = 0; i < 50; i++) begin
          rand_cmd(a, l, sz, bu);
          for (int k = 0; k < 8; k++) begin
            wd[k] = {$urandom, $urandom}; ws[k] = 8'($urandom);
          end
          do_write(a, 4'($urandom), l, sz, bu, ($urandom_range(0, 9) == 0), 1);
        end
      end
      begin
        logic [63:0] a; logic [7:0] l; logic [2:0] sz; logic [1:0] bu;
        for (int i = 0; i < 50; i++) begin
          rand_cmd(a, l, sz, bu);
          do_read(a, 4'($urandom), l, sz, bu, 1);
        end
      end
    join

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave (responder) backed by an internal 64-bit-wide memory array.
- Serves the AR/R and AW/W/B channels driven by the core's cache-side AXI master; sits at the far end of that master in simulation and SoC top-level.
- Read and write channels run independent FSMs and may be active at the same time.
- Supports FIXED and INCR bursts of 1..256 beats, narrow sizes up to 8 bytes, per-byte write strobes, SLVERR on illegal or out-of-range accesses.

Parameters:
- ADDR_BASE, 64'h8000_0000, byte address of memory word 0.
- DEPTH, 1024, number of 64-bit words.
- IDW, 4, AXI ID width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_awvalid in 1 / s_awready out 1 / s_awaddr in 64 / s_awid in IDW / s_awlen in 8 / s_awsize in 3 / s_awburst in 2  write address channel
- s_wvalid in 1 / s_wready out 1 / s_wdata in 64 / s_wstrb in 8 / s_wlast in 1  write data channel
- s_bvalid out 1 / s_bready in 1 / s_bresp out 2 / s_bid out IDW  write response channel
- s_arvalid in 1 / s_arready out 1 / s_araddr in 64 / s_arid in IDW / s_arlen in 8 / s_arsize in 3 / s_arburst in 2  read address channel
- s_rvalid out 1 / s_rready in 1 / s_rdata out 64 / s_rresp out 2 / s_rlast out 1 / s_rid out IDW  read data channel

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - While rst is high, all outputs are 0, including awready and arready.
  - Both FSMs return to IDLE and counters clear.
  - A reset mid-burst aborts it with no response; memory keeps beats already committed.
- Word index = (addr - ADDR_BASE) >> 3. A beat is in range iff addr >= ADDR_BASE and index < DEPTH.
- Address step per beat:
  - INCR: next = (addr aligned down to 2^size) + 2^size.
  - FIXED: address unchanged.
- Illegal command: size > 3, burst WRAP (2'b10), or burst 2'b11. It is still accepted for the full len+1 beats, but performs no memory access and responds SLVERR.
- Write FSM:
  - W_IDLE: awready=1. On aw_hs, latch addr/id/len/size/burst, clear beat_cnt and err, go to W_DATA.
  - W_DATA: wready=1. On each w_hs:
    - If the beat is in range and the command is legal, write the byte lanes selected by wstrb.
    - Otherwise set err.
    - Advance addr; beat_cnt++.
    - If wlast != (beat_cnt==len), set err.
    - When beat_cnt==len, go to W_RESP. The slave's own counter ends the burst, not wlast.
  - W_RESP: bvalid=1, bid=latched id, bresp = err ? 2'b10 : 2'b00. Hold until b_hs, then go to W_IDLE.
  - Earliest next awready is the cycle after b_hs.
- Read FSM:
  - R_IDLE: arready=1. On ar_hs, latch the command, load rdata from mem[index(araddr)], go to R_DATA.
  - R_DATA: rvalid=1, rid=latched id, rlast=(beat_cnt==len), rresp = 2'b10 if the beat is out of range or the command is illegal (rdata=0 then), else 2'b00.
  - rdata/rresp/rlast are held stable while rvalid && !rready.
  - On r_hs: advance addr, beat_cnt++, load rdata for the next beat in the same edge (full throughput, one beat per cycle).
  - On r_hs with rlast, go to R_IDLE.
- Latency: ar_hs at edge T gives rvalid high in cycle T+1. A single-beat write returns bvalid the cycle after w_hs.
- Narrow transfers:
  - Reads return the whole aligned 64-bit word; the master selects lanes.
  - Writes use only wstrb; awsize and low address bits do not mask strobes.
- Same-word read/write collision: a read-data load in the same edge as a write commit returns the old data.
- Write channel accepts W beats only after AW; W before AW stalls (wready=0 in W_IDLE).

Test Plan:
- Single write then read: AW addr 0x8000_0008 len 0 size 3, W data 0x1122334455667788 strb 0xFF, bready=1 → bvalid the cycle after w_hs with bresp 0. AR same addr → rvalid at T+1, rdata 0x1122334455667788, rlast=1, rresp 0.
- INCR burst with backpressure: write len 1 to 0x8000_0000 with data A,B. Read len 1 with rready toggling 1,0,1 → beats A then B; rdata stable during the stall; rlast only on B; returns to IDLE.
- Strobes: word preloaded 0xFFFF_FFFF_FFFF_FFFF, write 0 with strb 0x0F → readback 0xFFFF_FFFF_0000_0000.
- Errors:
  - Read at 0x8000_0000 + DEPTH*8 → rresp 2'b10, rdata 0.
  - Write with awburst 2'b10 len 1 → both beats accepted, no memory change, bresp 2'b10.
  - Write len 1 with wlast on beat 0 → bresp 2'b10.
- Concurrency and collision: overlap a write burst len 3 and a read burst len 3 to different regions → both complete and data is correct. Read load coinciding with a write to the same word → old value returned.
- Reset mid-read: rst asserted during beat 1 of a len 3 read → rvalid 0 next cycle; after release arready=1; a new read completes normally.
